// File: rtl/spi_host_sequencer.sv
// rtl/spi_host_sequencer.sv - SPI-SRAM frame sequencer: serialises cmd/addr/wdata on sdi, captures sdo for reads
module spi_host_sequencer #(
  parameter int               ADDR_W   = 8,
  parameter int               DATA_W   = 8,
  parameter int               CMD_W    = 8,
  parameter logic [CMD_W-1:0] CMD_WR   = 8'h02,
  parameter logic [CMD_W-1:0] CMD_RD   = 8'h03,
  parameter int               TURN_CYC = 2
) (
  input  logic              sck,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              sdi_o,
  output logic              la_o,
  output logic              da_o,
  input  logic              sdo_i,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int MAXW0 = (CMD_W > ADDR_W) ? CMD_W : ADDR_W;
  localparam int MAXW  = (MAXW0 > DATA_W) ? MAXW0 : DATA_W;
  localparam int MAXC  = (MAXW > TURN_CYC) ? MAXW : TURN_CYC;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, TURN, RDATA, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [MAXW-1:0]   tx, tx_n;
  logic [ADDR_W-1:0] addr_r, addr_n;
  logic [DATA_W-1:0] wdata_r, wdata_n, rx, rx_n, rdata_n;
  logic              we_r, we_n;
  logic              sdi_n, la_n, da_n, rv_n, busy_n, ready_n;

  // tx is left-aligned; its MSB is always the bit on sdi during the current cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tx_n    = tx;
    addr_n  = addr_r;
    wdata_n = wdata_r;
    we_n    = we_r;
    rx_n    = rx;
    rdata_n = rsp_rdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_n = CMD;
          cnt_n   = CW'(CMD_W - 1);
          we_n    = req_we;
          addr_n  = req_addr;
          wdata_n = req_wdata;
          tx_n    = MAXW'(req_we ? CMD_WR : CMD_RD) << (MAXW - CMD_W);
        end
      end
      CMD: begin
        if (cnt == '0) begin
          state_n = ADDR;
          cnt_n   = CW'(ADDR_W - 1);
          tx_n    = MAXW'(addr_r) << (MAXW - ADDR_W);
        end else begin
          cnt_n = cnt - CW'(1);
          tx_n  = tx << 1;
        end
      end
      ADDR: begin
        if (cnt == '0) begin
          tx_n = '0;
          if (we_r) begin
            state_n = WDATA;
            cnt_n   = CW'(DATA_W - 1);
            tx_n    = MAXW'(wdata_r) << (MAXW - DATA_W);
          end else if (TURN_CYC == 0) begin
            state_n = RDATA;
            cnt_n   = CW'(DATA_W - 1);
          end else begin
            state_n = TURN;
            cnt_n   = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
          end
        end else begin
          cnt_n = cnt - CW'(1);
          tx_n  = tx << 1;
        end
      end
      WDATA: begin
        if (cnt == '0) begin
          state_n = DONE;
          tx_n    = '0;
        end else begin
          cnt_n = cnt - CW'(1);
          tx_n  = tx << 1;
        end
      end
      TURN: begin
        if (cnt == '0) begin
          state_n = RDATA;
          cnt_n   = CW'(DATA_W - 1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RDATA: begin
        rx_n = {rx[DATA_W-2:0], sdo_i};
        if (cnt == '0) begin
          state_n = DONE;
          rdata_n = rx_n;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    sdi_n   = ((state_n == CMD) || (state_n == ADDR) || (state_n == WDATA)) && tx_n[MAXW-1];
    la_n    = (state_n == ADDR);
    da_n    = (state_n == WDATA) || (state_n == RDATA);
    rv_n    = (state_n == DONE);
    busy_n  = (state_n != IDLE);
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tx        <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      we_r      <= 1'b0;
      rx        <= '0;
      sdi_o     <= 1'b0;
      la_o      <= 1'b0;
      da_o      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tx        <= tx_n;
      addr_r    <= addr_n;
      wdata_r   <= wdata_n;
      we_r      <= we_n;
      rx        <= rx_n;
      sdi_o     <= sdi_n;
      la_o      <= la_n;
      da_o      <= da_n;
      rsp_valid <= rv_n;
      rsp_rdata <= rdata_n;
      busy      <= busy_n;
      req_ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_spi_host_sequencer.sv
// tb/tb_spi_host_sequencer.sv - frame-level reference model bench for spi_host_sequencer
module tb_spi_host_sequencer;

  localparam int AW = 8, DW = 8, CWD = 8, T = 2;
  localparam logic [7:0] OP_WR = 8'h02, OP_RD = 8'h03;
  localparam int RSTART = CWD + AW + T + 1;

  logic sck = 1'b0;
  always #5 sck = ~sck;

  logic       rst = 1'b1, req_valid = 1'b0, req_we = 1'b0, sdo_i = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, sdi_o, la_o, da_o, rsp_valid, busy;
  logic [7:0] rsp_rdata;

  logic       z_valid = 1'b0, z_we = 1'b0, z_sdo = 1'b0;
  logic [7:0] z_addr = 8'h55, z_wdata = 8'h00;
  logic       z_rdy, z_sdi, z_la, z_da, z_rv, z_busy;
  logic [7:0] z_rdata;

  spi_host_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CMD_W(CWD), .CMD_WR(OP_WR), .CMD_RD(OP_RD), .TURN_CYC(T)) dut (
    .sck(sck), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .sdi_o(sdi_o), .la_o(la_o), .da_o(da_o),
    .sdo_i(sdo_i), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy));

  spi_host_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CMD_W(CWD), .CMD_WR(OP_WR), .CMD_RD(OP_RD), .TURN_CYC(0)) zdut (
    .sck(sck), .rst(rst), .req_valid(z_valid), .req_ready(z_rdy), .req_we(z_we),
    .req_addr(z_addr), .req_wdata(z_wdata), .sdi_o(z_sdi), .la_o(z_la), .da_o(z_da),
    .sdo_i(z_sdo), .rsp_valid(z_rv), .rsp_rdata(z_rdata), .busy(z_busy));

  int n_total = 0, n_bad = 0;

  // frame-level model: a frame is (accept cycle, we, addr, wdata); outputs follow from the offset into it
  int         cyc = 0, acc = 0, n_acc = 0;
  bit         in_frame = 0, armed = 0, f_we = 0;
  logic [7:0] f_addr = '0, f_wdata = '0, rx = '0, exp_rdata = '0, rd_pat = '0;

  function automatic int done_k(input bit we);
    return CWD + AW + (we ? 0 : T) + DW + 1;
  endfunction

  always @(posedge sck) begin
    int k;
    bit acc_now;
    k = cyc - acc + 1;
    acc_now = 0;
    if (rst) begin
      in_frame = 0; exp_rdata = '0; rx = '0; armed = 1;
    end else begin
      if (in_frame && !f_we && k >= RSTART && k < RSTART + DW) begin
        rx = {rx[6:0], sdo_i};
        if (k == RSTART + DW - 1) exp_rdata = rx;
      end
      if ((!in_frame || k > done_k(f_we)) && req_valid) begin
        acc_now = 1; in_frame = 1; f_we = req_we; f_addr = req_addr; f_wdata = req_wdata; n_acc++;
      end
    end
    cyc++;
    if (acc_now) acc = cyc;
  end

  always @(negedge sck) begin
    int k;
    k = cyc - acc + 1;
    if (in_frame && !f_we && k >= RSTART && k < RSTART + DW) sdo_i = rd_pat[RSTART + DW - 1 - k];
    else sdo_i = 1'($urandom_range(0, 1));
  end

  always @(negedge sck) begin
    int k, dn;
    logic [15:0] hdr;
    logic e_sdi, e_la, e_da, e_rv, e_busy, e_rdy;
    if (armed) begin
      k = cyc - acc + 1;
      e_sdi = 0; e_la = 0; e_da = 0; e_rv = 0; e_busy = 0; e_rdy = 1;
      if (in_frame) begin
        dn = done_k(f_we);
        if (k <= dn) begin
          e_busy = 1; e_rdy = 0; e_rv = (k == dn);
          hdr = {f_we ? OP_WR : OP_RD, f_addr};
          if (k <= CWD + AW) e_sdi = hdr[CWD + AW - k];
          else if (f_we && k <= CWD + AW + DW) e_sdi = f_wdata[CWD + AW + DW - k];
          e_la = (k > CWD) && (k <= CWD + AW);
          e_da = f_we ? ((k > CWD + AW) && (k <= CWD + AW + DW)) : ((k >= RSTART) && (k < RSTART + DW));
        end
      end
      n_total++;
      if ({sdi_o, la_o, da_o, rsp_valid, busy, req_ready, rsp_rdata} !==
          {e_sdi, e_la, e_da, e_rv, e_busy, e_rdy, exp_rdata}) begin
        n_bad++;
        if (n_bad <= 20)
          $display("FAIL model_cycle k=%0d got sdi,la,da,rv,busy,rdy=%b%b%b%b%b%b rdata=%h required %b%b%b%b%b%b rdata=%h",
                   k, sdi_o, la_o, da_o, rsp_valid, busy, req_ready, rsp_rdata,
                   e_sdi, e_la, e_da, e_rv, e_busy, e_rdy, exp_rdata);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] seq(input logic [63:0] v, input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int k = lo; k <= hi; k++) r = (r << 1) | 64'(v[k]);
    return r;
  endfunction

  logic [63:0] l_sdi, l_la, l_da, l_rv, l_rdy;
  logic [7:0]  l_rdata;

  task automatic frame(input bit we, input logic [7:0] a, input logic [7:0] d, input logic [7:0] p, input int n);
    @(negedge sck);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; rd_pat = p;
    @(negedge sck);
    req_valid = 0;
    l_sdi = '0; l_la = '0; l_da = '0; l_rv = '0; l_rdy = '0; l_rdata = 'x;
    for (int k = 1; k <= n; k++) begin
      l_sdi[k] = sdi_o; l_la[k] = la_o; l_da[k] = da_o; l_rv[k] = rsp_valid; l_rdy[k] = req_ready;
      if (rsp_valid) l_rdata = rsp_rdata;
      if (k < n) @(negedge sck);
    end
  endtask

  logic [63:0] zl_da, zl_rv, zl_rdy;
  logic [7:0]  zpat, zrd;
  logic        seen;

  initial begin
    repeat (3) @(negedge sck);
    chk("reset_state", {sdi_o, la_o, da_o, rsp_valid, busy, req_ready, rsp_rdata}, {6'b000001, 8'h00});
    rst = 0;

    frame(1, 8'h3C, 8'hA5, 8'h00, 26);
    chk("wr_sdi", seq(l_sdi, 1, 24), 64'h023CA5);
    chk("wr_la", seq(l_la, 1, 26), 64'h3FC00);
    chk("wr_da", seq(l_da, 1, 26), 64'h3FC);
    chk("wr_rsp_valid", seq(l_rv, 1, 26), 64'h2);
    chk("wr_ready", seq(l_rdy, 1, 26), 64'h1);

    frame(0, 8'h81, 8'hFF, 8'h5E, 28);
    chk("rd_sdi", seq(l_sdi, 1, 28), 64'h0381000);
    chk("rd_da", seq(l_da, 1, 28), 64'h3FC);
    chk("rd_rsp_valid", seq(l_rv, 1, 28), 64'h2);
    chk("rd_rdata", 64'(l_rdata), 64'h5E);

    @(negedge sck);
    req_valid = 1; req_we = 1; req_addr = 8'hC7; req_wdata = 8'h3D;
    @(negedge sck);
    req_valid = 0;
    repeat (11) @(negedge sck);
    rst = 1;
    @(negedge sck);
    rst = 0;
    chk("rst_mid_outputs", {sdi_o, la_o, da_o, busy, req_ready, rsp_valid}, 6'b000010);
    chk("rst_mid_rdata", 64'(rsp_rdata), 64'h0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sck);
      seen = seen | rsp_valid;
    end
    chk("rst_mid_no_rsp", 64'(seen), 64'h0);
    frame(0, 8'h42, 8'h00, 8'hB7, 28);
    chk("rd_after_rst", 64'(l_rdata), 64'hB7);

    @(negedge sck);
    rst = 1; req_valid = 1; req_we = 0; req_addr = 8'h11;
    @(negedge sck);
    rst = 0; req_valid = 0;
    chk("rst_prio_ready", {busy, req_ready}, 2'b01);
    @(negedge sck);
    chk("rst_prio_idle", {busy, req_ready}, 2'b01);

    for (int i = 0; i < 300; i++) begin
      @(negedge sck);
      req_valid = 1; req_we = n_acc[0];
      req_addr = 8'($urandom); req_wdata = 8'($urandom); rd_pat = 8'($urandom);
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge sck);
      rst = ($urandom_range(0, 149) == 0);
      req_valid = ($urandom_range(0, 3) != 0); req_we = 1'($urandom_range(0, 1));
      req_addr = 8'($urandom); req_wdata = 8'($urandom); rd_pat = 8'($urandom);
    end
    @(negedge sck);
    rst = 0; req_valid = 0;
    repeat (30) @(negedge sck);
    chk("accepts_seen", 64'(n_acc > 20), 64'h1);

    zpat = 8'hC3; zrd = 'x;
    @(negedge sck);
    z_valid = 1;
    @(negedge sck);
    z_valid = 0;
    zl_da = '0; zl_rv = '0; zl_rdy = '0;
    for (int k = 1; k <= 27; k++) begin
      z_sdo = (k >= 17 && k <= 24) ? zpat[24 - k] : 1'b0;
      zl_da[k] = z_da; zl_rv[k] = z_rv; zl_rdy[k] = z_rdy;
      if (z_rv) zrd = z_rdata;
      if (k < 27) @(negedge sck);
    end
    chk("t0_da", seq(zl_da, 1, 27), 64'h7F8);
    chk("t0_rsp_valid", seq(zl_rv, 1, 27), 64'h4);
    chk("t0_ready", seq(zl_rdy, 1, 27), 64'h3);
    chk("t0_rdata", 64'(zrd), 64'hC3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_host_sequencer.md
Name: spi_host_sequencer

Overview:
- Upstream frame generator for the SPI-SRAM slave datapath. Runs on the same sck.
- Accepts one parallel read or write request per valid/ready handshake.
- Serialises command, address and write data MSB-first onto the slave's sdi input, driving the slave's lA/dA phase strobes.
- For reads, it shifts the slave's sdo back in and returns the byte on a one-cycle response strobe.

Parameters:
- ADDR_W, 8: address width in bits; address phase length in cycles.
- DATA_W, 8: data width in bits; data phase length in cycles.
- CMD_W, 8: command width in bits; command phase length in cycles.
- CMD_WR, 8'h02: opcode sent for writes.
- CMD_RD, 8'h03: opcode sent for reads.
- TURN_CYC, 2: idle cycles between the read address phase and the first sampled sdo bit; legal range 0..15.

Ports:
- sck  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; a request is accepted on an edge with req_valid && req_ready.
- req_we  input  1  1 = write, 0 = read; sampled at accept.
- req_addr  input  ADDR_W  target address; sampled at accept.
- req_wdata  input  DATA_W  write data; sampled at accept, ignored for reads.
- sdi_o  output  1  serial stream to slave sdi.
- la_o  output  1  address-phase strobe to slave lA.
- da_o  output  1  data-phase strobe to slave dA.
- sdo_i  input  1  serial read data from slave.
- rsp_valid  output  1  one-cycle pulse at frame completion.
- rsp_rdata  output  DATA_W  read byte; valid while rsp_valid is high and held until the next read completes.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE; req_ready=1 after reset.
  - sdi_o=0, la_o=0, da_o=0, rsp_valid=0, busy=0, rsp_rdata=0.
  - Shift registers and counters cleared.
- States: IDLE, CMD, ADDR, WDATA, TURN, RDATA, DONE. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On accept: latch the opcode (CMD_WR if req_we, else CMD_RD), req_addr, req_wdata and the we flag into internal registers; load the phase counter with CMD_W-1; next state CMD.
  - Request inputs are ignored in all other states; no queueing.
- CMD: sdi_o = current opcode MSB, shifted left each cycle. After CMD_W cycles, go to ADDR with the counter loaded to ADDR_W-1.
- ADDR:
  - sdi_o = address bits MSB-first; la_o=1 for exactly ADDR_W cycles.
  - Then go to WDATA if we, else TURN. If TURN_CYC=0, go directly to RDATA.
- WDATA: sdi_o = wdata bits MSB-first; da_o=1 for exactly DATA_W cycles; then DONE.
- TURN: sdi_o=0, la_o=0, da_o=0 for TURN_CYC cycles; then RDATA.
- RDATA:
  - da_o=1, sdi_o=0.
  - sdo_i is sampled at each rising edge during the DATA_W cycles and shifted in MSB-first.
  - Then DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle.
  - On reads, rsp_rdata is updated to the assembled byte in the same cycle. Writes leave rsp_rdata unchanged.
  - Next state IDLE.
- Outside their phases: sdi_o=0, la_o=0, da_o=0.
- Latency from the accept edge:
  - Write: DONE occupies cycle CMD_W+ADDR_W+DATA_W+1 (25 at defaults).
  - Read: DONE occupies cycle CMD_W+ADDR_W+TURN_CYC+DATA_W+1 (27 at defaults).
  - req_ready returns the cycle after DONE.
- Back-to-back: a new request can be accepted on the first IDLE edge after DONE. There is a minimum of one IDLE cycle between frames.
- Reset mid-frame:
  - The frame is aborted with no rsp_valid.
  - All strobes drop on the next cycle.
  - rsp_rdata is cleared to 0.
- rst has priority over the accept handshake on the same edge.
- Counters are sized to the largest of CMD_W, ADDR_W, DATA_W and TURN_CYC. No wrap-around beyond the phase lengths.

Test Plan:
- Write req_we=1, addr=0x3C, wdata=0xA5:
  - sdi_o over cycles 1..24 = 00000010 00111100 10100101.
  - la_o high on cycles 9..16; da_o high on cycles 17..24.
  - rsp_valid high on cycle 25 only; req_ready=1 on cycle 26.
- Read req_we=0, addr=0x81, with the bench driving sdo_i = 0x5E MSB-first on cycles 19..26:
  - sdi_o shows 00000011 10000001 then 0s.
  - rsp_valid on cycle 27 with rsp_rdata=0x5E.
- Assert req_valid continuously with alternating we:
  - Exactly one accept per frame, one IDLE gap between frames.
  - req_ready=0 throughout each frame.
  - A write does not alter rsp_rdata.
- Assert rst at cycle 12 of a write frame:
  - Next cycle: sdi_o=la_o=da_o=0, busy=0, req_ready=1.
  - No rsp_valid pulse.
  - A subsequent read completes normally.
- Rebuild with TURN_CYC=0 and read:
  - RDATA starts on cycle 17.
  - rsp_valid on cycle 25 with the correct byte.
- Assert rst and req_valid on the same edge: the request is not accepted and the state stays IDLE.
